// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the pc, issues one ROM read per instruction,
// waits out the ROM latency and hands {instr, pc} to the core via valid/ready.
module instr_fetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter int                INSTR_W  = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                ROM_LAT  = 1
) (
   input  logic               clk,
   input  logic               rst,
   output logic [ADDR_W-1:0]  rom_addr,
   output logic               rom_rd,
   input  logic [INSTR_W-1:0] rom_data,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               redirect_en,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic [ADDR_W-1:0]  pc
);

   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t             r_state, w_state_next;
   logic [ADDR_W-1:0]  r_pc, w_pc_next;
   logic [ADDR_W-1:0]  r_rom_addr, w_rom_addr_next;
   logic               r_rom_rd, w_rom_rd_next;
   logic [CNT_W-1:0]   r_cnt, w_cnt_next;
   logic [INSTR_W-1:0] r_instr_out, w_instr_out_next;
   logic [ADDR_W-1:0]  r_instr_pc, w_instr_pc_next;
   logic               r_valid, w_valid_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_pc_next        = r_pc;
      w_rom_addr_next  = r_rom_addr;
      w_rom_rd_next    = 1'b0;
      w_cnt_next       = r_cnt;
      w_instr_out_next = r_instr_out;
      w_instr_pc_next  = r_instr_pc;
      w_valid_next     = r_valid;
      unique case (r_state)
         S_IDLE: begin
            w_state_next = S_REQ;
            if (redirect_en) begin
               w_pc_next = redirect_pc;
            end
         end
         S_REQ: begin
            // A held redirect keeps us here so no read is issued for a stale pc.
            if (redirect_en) begin
               w_pc_next = redirect_pc;
            end else begin
               w_rom_addr_next = r_pc;
               w_rom_rd_next   = 1'b1;
               w_cnt_next      = CNT_W'(ROM_LAT);
               w_state_next    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_en) begin
               w_pc_next    = redirect_pc;
               w_state_next = S_REQ;
            end else if (!r_rom_rd) begin
               // The strobe cycle itself is not counted: ROM data lands
               // ROM_LAT cycles after the strobe is seen on the port.
               w_cnt_next = r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  w_instr_out_next = rom_data;
                  w_instr_pc_next  = r_pc;
                  w_valid_next     = 1'b1;
                  w_pc_next        = r_pc + ADDR_W'(1);
                  w_state_next     = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (redirect_en) begin
               w_pc_next    = redirect_pc;
               w_valid_next = 1'b0;
               w_state_next = S_REQ;
            end else if (instr_ready) begin
               w_valid_next = 1'b0;
               w_state_next = S_REQ;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc        <= RESET_PC;
         r_rom_addr  <= '0;
         r_rom_rd    <= 1'b0;
         r_cnt       <= '0;
         r_instr_out <= '0;
         r_instr_pc  <= '0;
         r_valid     <= 1'b0;
      end else begin
         r_pc        <= w_pc_next;
         r_rom_addr  <= w_rom_addr_next;
         r_rom_rd    <= w_rom_rd_next;
         r_cnt       <= w_cnt_next;
         r_instr_out <= w_instr_out_next;
         r_instr_pc  <= w_instr_pc_next;
         r_valid     <= w_valid_next;
      end
   end

   assign rom_addr    = r_rom_addr;
   assign rom_rd      = r_rom_rd;
   assign instr_out   = r_instr_out;
   assign instr_pc    = r_instr_pc;
   assign instr_valid = r_valid;
   assign pc          = r_pc;

endmodule
